// File: rtl/ptmch_trg_multi_if.sv
// Snoop-side bundle for ptmch_trg_multi: SPI bus inputs, channel configuration and status outputs.
// master = bus/config owner, slave = the trigger block.
interface ptmch_trg_multi_if #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned ADRW = 24,
  parameter int unsigned CNTW = 8
);
  logic                   SPI_CS;
  logic                   SPI_MOSI;
  logic [NCH*8-1:0]       CFG_OPC;
  logic [NCH*8-1:0]       CFG_MSK;
  logic [NCH-1:0]         CFG_ADR_EN;
  logic [NCH*ADRW-1:0]    CFG_ADR_LO;
  logic [NCH*ADRW-1:0]    CFG_ADR_HI;
  logic                   CNT_CLR;
  logic [7:0]             OPC;
  logic                   OPC_VLD;
  logic [ADRW-1:0]        ADR;
  logic                   ADR_VLD;
  logic [NCH-1:0]         TRG_HIT;
  logic [NCH-1:0]         TRG_STB;
  logic [NCH*CNTW-1:0]    HIT_CNT;

  modport master (
    output SPI_CS, SPI_MOSI, CFG_OPC, CFG_MSK, CFG_ADR_EN, CFG_ADR_LO, CFG_ADR_HI, CNT_CLR,
    input  OPC, OPC_VLD, ADR, ADR_VLD, TRG_HIT, TRG_STB, HIT_CNT
  );

  modport slave (
    input  SPI_CS, SPI_MOSI, CFG_OPC, CFG_MSK, CFG_ADR_EN, CFG_ADR_LO, CFG_ADR_HI, CNT_CLR,
    output OPC, OPC_VLD, ADR, ADR_VLD, TRG_HIT, TRG_STB, HIT_CNT
  );
endinterface

// File: rtl/ptmch_trg_multi.sv
// Multi-channel SPI flash snoop trigger: decodes opcode and optional address (mode 0, MSB first)
// and raises per-channel hit flags, one-cycle strobes and saturating hit counters.
module ptmch_trg_multi #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned ADRW = 24,
  parameter int unsigned CNTW = 8
) (
  input logic                SPI_CLK,
  input logic                RESET_N,
  ptmch_trg_multi_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StOpc, StAdr, StData} state_e;

  localparam logic [5:0] OpcLast = 6'd7;
  localparam logic [5:0] AdrLast = 6'(8 + ADRW - 1);
  localparam logic [5:0] BitEnd  = 6'(8 + ADRW);

  state_e                    state_q, state_d;
  logic [5:0]                bitcnt_q, bitcnt_d;
  logic [ADRW-1:0]           shift_q, shift_d;
  logic                      opc_vld_q, opc_vld_d;
  logic                      adr_vld_q, adr_vld_d;
  logic [NCH-1:0]            trg_hit_q, trg_hit_d;
  logic [NCH-1:0]            trg_stb_q, trg_stb_d;
  logic [7:0]                opc_q, opc_d;
  logic [ADRW-1:0]           adr_q, adr_d;
  logic [NCH-1:0][CNTW-1:0]  cnt_q, cnt_d;

  logic [7:0]                opc_new;
  logic [ADRW-1:0]           adr_new;
  logic [NCH-1:0]            opc_hit_new, opc_hit_cur, in_win, fire;

  // Chip select high holds all per-transaction state in reset.
  logic txn_rst_n;
  assign txn_rst_n = RESET_N & ~bus.SPI_CS;

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = (bitcnt_q == BitEnd) ? bitcnt_q : bitcnt_q + 6'd1;
    shift_d   = {shift_q[ADRW-2:0], bus.SPI_MOSI};
    opc_d     = opc_q;
    opc_vld_d = opc_vld_q;
    adr_d     = adr_q;
    adr_vld_d = adr_vld_q;
    fire      = '0;
    opc_new   = {shift_q[6:0], bus.SPI_MOSI};
    adr_new   = shift_d;
    opc_hit_new = '0;
    opc_hit_cur = '0;
    in_win      = '0;

    for (int unsigned n = 0; n < NCH; n++) begin
      opc_hit_new[n] = ((opc_new ^ bus.CFG_OPC[8*n +: 8]) & bus.CFG_MSK[8*n +: 8]) == 8'h00;
      opc_hit_cur[n] = ((opc_q ^ bus.CFG_OPC[8*n +: 8]) & bus.CFG_MSK[8*n +: 8]) == 8'h00;
      in_win[n]      = (bus.CFG_ADR_LO[n*ADRW +: ADRW] <= adr_new) &&
                       (adr_new <= bus.CFG_ADR_HI[n*ADRW +: ADRW]);
    end

    unique case (state_q)
      StIdle: state_d = StOpc;
      StOpc: begin
        if (bitcnt_q == OpcLast) begin
          opc_d     = opc_new;
          opc_vld_d = 1'b1;
          fire      = opc_hit_new & ~bus.CFG_ADR_EN;
          state_d   = |(opc_hit_new & bus.CFG_ADR_EN) ? StAdr : StData;
        end
      end
      StAdr: begin
        // opc_q already holds this transaction's opcode here.
        if (bitcnt_q == AdrLast) begin
          adr_d     = adr_new;
          adr_vld_d = 1'b1;
          fire      = opc_hit_cur & bus.CFG_ADR_EN & in_win;
          state_d   = StData;
        end
      end
      StData: state_d = StData;
    endcase

    trg_hit_d = trg_hit_q | fire;
    trg_stb_d = fire;

    cnt_d = cnt_q;
    if (bus.CNT_CLR) begin
      cnt_d = '0;
    end else begin
      for (int unsigned n = 0; n < NCH; n++) begin
        if (fire[n] && (cnt_q[n] != {CNTW{1'b1}})) cnt_d[n] = cnt_q[n] + 1'b1;
      end
    end
  end

  always_ff @(posedge SPI_CLK or negedge txn_rst_n) begin
    if (!txn_rst_n) begin
      state_q   <= StIdle;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      opc_vld_q <= 1'b0;
      adr_vld_q <= 1'b0;
      trg_hit_q <= '0;
      trg_stb_q <= '0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      opc_vld_q <= opc_vld_d;
      adr_vld_q <= adr_vld_d;
      trg_hit_q <= trg_hit_d;
      trg_stb_q <= trg_stb_d;
    end
  end

  always_ff @(posedge SPI_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      opc_q <= '0;
      adr_q <= '0;
      cnt_q <= '0;
    end else begin
      opc_q <= opc_d;
      adr_q <= adr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.OPC     = opc_q;
  assign bus.OPC_VLD = opc_vld_q;
  assign bus.ADR     = adr_q;
  assign bus.ADR_VLD = adr_vld_q;
  assign bus.TRG_HIT = trg_hit_q;
  assign bus.TRG_STB = trg_stb_q;
  assign bus.HIT_CNT = cnt_q;

endmodule

// File: tb/tb_ptmch_trg_multi.sv
// Bench for ptmch_trg_multi: directed vector table, hand sequences and random transactions
// checked every SPI_CLK edge against a transaction-level model.
module tb_ptmch_trg_multi;
  localparam int unsigned NCH   = 4;
  localparam int unsigned ADRW  = 24;
  localparam int unsigned CNTW  = 8;
  localparam int unsigned FRAME = 8 + ADRW;

  typedef logic [ADRW-1:0] adr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ptmch_trg_multi_if #(.NCH(NCH), .ADRW(ADRW), .CNTW(CNTW)) bus ();
  ptmch_trg_multi #(.NCH(NCH), .ADRW(ADRW), .CNTW(CNTW)) dut (
    .SPI_CLK (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  logic [7:0]     cfg_opc [NCH];
  logic [7:0]     cfg_msk [NCH];
  logic [NCH-1:0] cfg_en;
  adr_t           cfg_lo  [NCH];
  adr_t           cfg_hi  [NCH];

  logic           q_bits [$];
  logic [7:0]     m_opc;
  adr_t           m_adr;
  logic [CNTW-1:0] m_cnt [NCH];
  logic [NCH-1:0] m_hit, m_stb;
  logic           m_ov, m_av;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [7:0]     opc;
    adr_t           adr;
    int             nbits;
    logic [NCH-1:0] exp_hit;
    logic           exp_av;
    logic           chk_adr;
    adr_t           exp_adr;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NCH*CNTW-1:0] cnt_vec();
    logic [NCH*CNTW-1:0] v;
    for (int n = 0; n < NCH; n++) v[n*CNTW +: CNTW] = m_cnt[n];
    return v;
  endfunction

  function automatic logic [31:0] field(input int start, input int len);
    logic [31:0] v = '0;
    for (int i = 0; i < len; i++) v = {v[30:0], q_bits[start+i]};
    return v;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, " OPC"},     64'(bus.OPC),     64'(m_opc));
    check({tag, " OPC_VLD"}, 64'(bus.OPC_VLD), 64'(m_ov));
    check({tag, " ADR"},     64'(bus.ADR),     64'(m_adr));
    check({tag, " ADR_VLD"}, 64'(bus.ADR_VLD), 64'(m_av));
    check({tag, " TRG_HIT"}, 64'(bus.TRG_HIT), 64'(m_hit));
    check({tag, " TRG_STB"}, 64'(bus.TRG_STB), 64'(m_stb));
    check({tag, " HIT_CNT"}, 64'(bus.HIT_CNT), 64'(cnt_vec()));
  endtask

  task automatic apply_cfg();
    for (int n = 0; n < NCH; n++) begin
      bus.CFG_OPC[8*n +: 8]          = cfg_opc[n];
      bus.CFG_MSK[8*n +: 8]          = cfg_msk[n];
      bus.CFG_ADR_LO[n*ADRW +: ADRW] = cfg_lo[n];
      bus.CFG_ADR_HI[n*ADRW +: ADRW] = cfg_hi[n];
    end
    bus.CFG_ADR_EN = cfg_en;
  endtask

  task automatic cfg_default();
    cfg_opc = '{8'h10, 8'h0F, 8'hD8, 8'h13};
    cfg_msk = '{8'hFF, 8'hF0, 8'hFF, 8'hFF};
    cfg_en  = 4'b0100;
    for (int n = 0; n < NCH; n++) begin
      cfg_lo[n] = 24'h000000;
      cfg_hi[n] = 24'hFFFFFF;
    end
    cfg_lo[2] = 24'h020000;
    cfg_hi[2] = 24'h03FFFF;
    apply_cfg();
  endtask

  // One rising edge: drive the bit on the falling edge, then predict from the bits seen so far.
  task automatic edge_bit(input logic b, input logic clr);
    logic [7:0]     op;
    adr_t           ad;
    logic [NCH-1:0] mt, hit, stb;
    logic           aphase;
    int             k;
    @(negedge clk);
    bus.SPI_CS   = 1'b0;
    bus.SPI_MOSI = b;
    bus.CNT_CLR  = clr;
    @(posedge clk);
    q_bits.push_back(b);
    k = q_bits.size();
    mt = '0; hit = '0; stb = '0; aphase = 1'b0;
    if (k >= 8) begin
      op = 8'(field(0, 8));
      for (int n = 0; n < NCH; n++) mt[n] = ((op ^ cfg_opc[n]) & cfg_msk[n]) == 8'h00;
      aphase = |(mt & cfg_en);
      hit    = mt & ~cfg_en;
      if (k == 8) begin
        stb   = hit;
        m_opc = op;
      end
      if (aphase && k >= FRAME) begin
        ad = adr_t'(field(8, ADRW));
        for (int n = 0; n < NCH; n++) begin
          if (mt[n] && cfg_en[n] && cfg_lo[n] <= ad && ad <= cfg_hi[n]) begin
            hit[n] = 1'b1;
            if (k == FRAME) stb[n] = 1'b1;
          end
        end
        if (k == FRAME) m_adr = ad;
      end
    end
    for (int n = 0; n < NCH; n++) begin
      if (clr) m_cnt[n] = '0;
      else if (stb[n] && m_cnt[n] != {CNTW{1'b1}}) m_cnt[n] = m_cnt[n] + 1'b1;
    end
    m_hit = hit;
    m_stb = stb;
    m_ov  = (k >= 8);
    m_av  = aphase && (k >= FRAME);
    #1;
    compare_all($sformatf("edge%0d", k));
  endtask

  task automatic send_txn(input logic [7:0] opc, input adr_t adr, input int nbits,
                          input int clr_at);
    logic [FRAME-1:0] fr;
    fr = {opc, adr};
    for (int i = 0; i < nbits; i++)
      edge_bit((i < FRAME) ? fr[FRAME-1-i] : 1'($urandom), i == clr_at);
  endtask

  task automatic end_txn();
    @(negedge clk);
    bus.SPI_CS  = 1'b1;
    bus.CNT_CLR = 1'b0;
    #1;
    q_bits.delete();
    m_hit = '0; m_stb = '0; m_ov = 1'b0; m_av = 1'b0;
    compare_all("cs_high");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] ropc;
    adr_t       radr;
    int         c, nb, ca;

    vecs[0] = '{8'h10, 24'hABCDEF, 32, 4'b0001, 1'b0, 1'b0, 24'h000000};
    vecs[1] = '{8'h05, 24'h000000,  8, 4'b0010, 1'b0, 1'b0, 24'h000000};
    vecs[2] = '{8'h15, 24'h000000,  8, 4'b0000, 1'b0, 1'b0, 24'h000000};
    vecs[3] = '{8'hD8, 24'h020000, 32, 4'b0100, 1'b1, 1'b1, 24'h020000};
    vecs[4] = '{8'hD8, 24'h03FFFF, 32, 4'b0100, 1'b1, 1'b1, 24'h03FFFF};
    vecs[5] = '{8'hD8, 24'h040000, 32, 4'b0000, 1'b1, 1'b1, 24'h040000};
    vecs[6] = '{8'hD8, 24'h01FFFF, 32, 4'b0000, 1'b1, 1'b1, 24'h01FFFF};
    vecs[7] = '{8'h13, 24'h000000,  8, 4'b1000, 1'b0, 1'b0, 24'h000000};
    vecs[8] = '{8'hD8, 24'h030000, 28, 4'b0000, 1'b0, 1'b1, 24'h01FFFF};
    vecs[9] = '{8'h10, 24'h000000,  5, 4'b0000, 1'b0, 1'b0, 24'h000000};

    bus.SPI_CS = 1'b1; bus.SPI_MOSI = 1'b0; bus.CNT_CLR = 1'b0;
    cfg_default();
    m_opc = '0; m_adr = '0; m_hit = '0; m_stb = '0; m_ov = 1'b0; m_av = 1'b0;
    for (int n = 0; n < NCH; n++) m_cnt[n] = '0;
    repeat (3) @(negedge clk);
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Opcode-only hit, strobe one cycle, hit held until CS rises.
    send_txn(8'h10, 24'h123456, 8, -1);
    check("h1 TRG_HIT", 64'(bus.TRG_HIT), 64'h1);
    check("h1 TRG_STB", 64'(bus.TRG_STB), 64'h1);
    check("h1 OPC", 64'(bus.OPC), 64'h10);
    check("h1 HIT_CNT0", 64'(bus.HIT_CNT[7:0]), 64'h1);
    edge_bit(1'b0, 1'b0);
    check("h1 TRG_STB after edge9", 64'(bus.TRG_STB), 64'h0);
    check("h1 TRG_HIT after edge9", 64'(bus.TRG_HIT), 64'h1);
    for (int i = 0; i < 23; i++) edge_bit(1'($urandom), 1'b0);
    check("h1 ADR_VLD", 64'(bus.ADR_VLD), 64'h0);
    end_txn();
    check("h1 TRG_HIT after cs", 64'(bus.TRG_HIT), 64'h0);

    for (int v = 0; v < 10; v++) begin
      send_txn(vecs[v].opc, vecs[v].adr, vecs[v].nbits, -1);
      check($sformatf("vec%0d TRG_HIT", v), 64'(bus.TRG_HIT), 64'(vecs[v].exp_hit));
      check($sformatf("vec%0d ADR_VLD", v), 64'(bus.ADR_VLD), 64'(vecs[v].exp_av));
      end_txn();
      if (vecs[v].chk_adr) check($sformatf("vec%0d ADR", v), 64'(bus.ADR), 64'(vecs[v].exp_adr));
    end

    // Saturation, then clear on a firing edge wins over the increment.
    for (int i = 0; i < 260; i++) begin
      send_txn(8'h10, 24'h0, 8, -1);
      end_txn();
    end
    check("sat HIT_CNT0", 64'(bus.HIT_CNT[7:0]), 64'd255);
    send_txn(8'h10, 24'h0, 8, 7);
    check("clr HIT_CNT0", 64'(bus.HIT_CNT[7:0]), 64'd0);
    end_txn();

    // Two channels on one opcode fire together.
    cfg_opc[0] = 8'h13;
    apply_cfg();
    send_txn(8'h13, 24'h0, 8, -1);
    check("dual TRG_STB", 64'(bus.TRG_STB), 64'h9);
    check("dual HIT_CNT0", 64'(bus.HIT_CNT[7:0]), 64'd1);
    check("dual HIT_CNT3", 64'(bus.HIT_CNT[31:24]), 64'd1);
    end_txn();

    // Aborted opcode is discarded; next full transaction hits.
    cfg_opc[0] = 8'h10;
    apply_cfg();
    send_txn(8'h10, 24'h0, 5, -1);
    end_txn();
    check("abort OPC", 64'(bus.OPC), 64'h13);
    check("abort HIT_CNT0", 64'(bus.HIT_CNT[7:0]), 64'd1);
    send_txn(8'h10, 24'h0, 8, -1);
    check("retry TRG_HIT", 64'(bus.TRG_HIT), 64'h1);
    check("retry HIT_CNT0", 64'(bus.HIT_CNT[7:0]), 64'd2);

    // Asynchronous reset mid-transaction clears everything at once.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst OPC", 64'(bus.OPC), 64'h0);
    check("rst OPC_VLD", 64'(bus.OPC_VLD), 64'h0);
    check("rst TRG_HIT", 64'(bus.TRG_HIT), 64'h0);
    check("rst TRG_STB", 64'(bus.TRG_STB), 64'h0);
    check("rst HIT_CNT", 64'(bus.HIT_CNT), 64'h0);
    m_opc = '0; m_adr = '0;
    for (int n = 0; n < NCH; n++) m_cnt[n] = '0;
    end_txn();
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 150; t++) begin
      for (int n = 0; n < NCH; n++) begin
        cfg_opc[n] = 8'($urandom);
        cfg_msk[n] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
        cfg_en[n]  = 1'($urandom);
        cfg_lo[n]  = adr_t'($urandom_range(0, 32'h000F_FFFF));
        if ($urandom_range(0, 4) == 0) cfg_hi[n] = cfg_lo[n] - 1'b1;
        else cfg_hi[n] = cfg_lo[n] + adr_t'($urandom_range(0, 32'h0000_FFFF));
      end
      apply_cfg();
      c = $urandom_range(0, NCH - 1);
      if ($urandom_range(0, 3) != 0) ropc = cfg_opc[c] ^ (8'($urandom) & ~cfg_msk[c]);
      else ropc = 8'($urandom);
      c = $urandom_range(0, NCH - 1);
      case ($urandom_range(0, 4))
        0: radr = cfg_lo[c];
        1: radr = cfg_hi[c];
        2: radr = cfg_lo[c] - 1'b1;
        3: radr = cfg_hi[c] + 1'b1;
        default: radr = adr_t'($urandom);
      endcase
      nb = $urandom_range(0, 44);
      ca = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 44) : -1;
      send_txn(ropc, radr, nb, ca);
      end_txn();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
